// File: rtl/tone_player.sv
// tone_player - table-driven square-wave tone generator.
//
// Holds NUM_TONES tone periods (microseconds).  A start request in IDLE
// latches the selected period and a duration in milliseconds.  The block
// then drives a square wave on speaker until the duration expires, and
// pulses done for one cycle.
//
// Ports:
//   clk            system clock
//   reset_n        asynchronous active-low reset
//   start          play request, sampled only in IDLE
//   stop           abort playback (also suppresses a start in IDLE)
//   tone_sel       table index, latched on accepted start
//   duration_ms    play length in ms, latched on accepted start
//   speaker        square-wave output, low whenever not playing
//   busy           high while in PLAY
//   done           one-cycle pulse on normal completion
//   err            one-cycle pulse when start names a missing table entry
//   cur_period_us  period of the current or last accepted tone
//
// State | meaning
// IDLE  | waiting for start; counters held at zero
// PLAY  | tone running; busy high
// DONE  | one-cycle completion pulse, then IDLE

module tone_player #(
  parameter int CLKS_PER_US = 50,
  parameter int NUM_TONES   = 5,
  parameter int PERIOD_W    = 13,
  parameter int DUR_W       = 12,
  parameter int SEL_W       = 3,
  parameter logic [NUM_TONES*PERIOD_W-1:0] TONE_TABLE =
    {13'd1667, 13'd2000, 13'd2500, 13'd3333, 13'd5000}
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                start,
  input  logic                stop,
  input  logic [SEL_W-1:0]    tone_sel,
  input  logic [DUR_W-1:0]    duration_ms,
  output logic                speaker,
  output logic                busy,
  output logic                done,
  output logic                err,
  output logic [PERIOD_W-1:0] cur_period_us
);

  localparam int              PRE_W   = (CLKS_PER_US > 1) ? $clog2(CLKS_PER_US) : 1;
  localparam int              HALF_W  = PERIOD_W - 1;
  localparam logic [PRE_W-1:0] PRE_MAX = PRE_W'(CLKS_PER_US - 1);
  localparam logic [9:0]      US_MAX  = 10'd999;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PLAY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state, state_nxt;

  logic [PRE_W-1:0]    presc;
  logic [HALF_W-1:0]   half_cnt;
  logic [HALF_W-1:0]   half_q;
  logic [9:0]          us_cnt;
  logic [DUR_W-1:0]    ms_cnt;
  logic [DUR_W-1:0]    dur_q;

  logic [PERIOD_W-1:0] sel_period;
  logic [HALF_W-1:0]   sel_half;
  logic                sel_valid;
  logic                req;
  logic                accept;
  logic                us_tick;
  logic                half_wrap;
  logic                expire;

  // Table lookup; an out-of-range select yields zero and is never latched.
  always_comb begin
    sel_period = '0;
    for (int unsigned i = 0; i < NUM_TONES; i++) begin
      if (32'(tone_sel) == i) sel_period = TONE_TABLE[i*PERIOD_W +: PERIOD_W];
    end
  end

  // Half period in us; a zero half would never toggle, so clamp to 1.
  always_comb begin
    sel_half = sel_period[PERIOD_W-1:1];
    if (sel_half == '0) sel_half = HALF_W'(1);
  end

  assign sel_valid = (32'(tone_sel) < $unsigned(NUM_TONES));
  assign req       = (state == IDLE) && start && !stop;
  assign accept    = req && sel_valid;
  assign us_tick   = (presc == PRE_MAX);
  assign half_wrap = us_tick && (half_cnt == half_q - HALF_W'(1));
  assign expire    = (state == PLAY) && us_tick && (us_cnt == US_MAX) &&
                     (ms_cnt == dur_q - DUR_W'(1));

  assign busy = (state == PLAY);
  assign done = (state == DONE);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (accept) state_nxt = (duration_ms == '0) ? DONE : PLAY;
      end
      PLAY: begin
        if (stop)        state_nxt = IDLE;
        else if (expire) state_nxt = DONE;
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      err           <= 1'b0;
      speaker       <= 1'b0;
      cur_period_us <= '0;
      half_q        <= '0;
      dur_q         <= '0;
    end else begin
      err <= req && !sel_valid;
      if (accept) begin
        cur_period_us <= sel_period;
        half_q        <= sel_half;
        dur_q         <= duration_ms;
      end
      // Expiry and stop both override a coincident toggle.
      if ((state == PLAY) && !stop && !expire) begin
        if (half_wrap) speaker <= ~speaker;
      end else begin
        speaker <= 1'b0;
      end
    end
  end

  // Counters run only in PLAY; outside it they sit at zero so an accepted
  // start always begins from a clean time base.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      presc    <= '0;
      half_cnt <= '0;
      us_cnt   <= '0;
      ms_cnt   <= '0;
    end else if ((state == PLAY) && !stop) begin
      presc <= us_tick ? '0 : presc + PRE_W'(1);
      if (us_tick) begin
        half_cnt <= half_wrap ? '0 : half_cnt + HALF_W'(1);
        if (us_cnt == US_MAX) begin
          us_cnt <= '0;
          ms_cnt <= ms_cnt + DUR_W'(1);
        end else begin
          us_cnt <= us_cnt + 10'd1;
        end
      end
    end else begin
      presc    <= '0;
      half_cnt <= '0;
      us_cnt   <= '0;
      ms_cnt   <= '0;
    end
  end

endmodule

// File: tb/tb_tone_player.sv
module tb_tone_player;

  localparam int C = 2;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        start;
  logic        stop;
  logic [2:0]  tone_sel;
  logic [11:0] duration_ms;
  logic        speaker;
  logic        busy;
  logic        done;
  logic        err;
  logic [12:0] cur_period_us;

  int vectors = 0;
  int miscompares = 0;
  int tab[5] = '{5000, 3333, 2500, 2000, 1667};
  int last_period = 0;

  tone_player #(.CLKS_PER_US(C)) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .start         (start),
    .stop          (stop),
    .tone_sel      (tone_sel),
    .duration_ms   (duration_ms),
    .speaker       (speaker),
    .busy          (busy),
    .done          (done),
    .err           (err),
    .cur_period_us (cur_period_us)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Plays one tone starting in the current cycle and checks every cycle
  // against a closed-form model. poke_at > 0 raises start at that offset.
  task automatic run_play(input int sel, input int dur, input int poke_at, input string tag);
    int half;
    int len;
    logic [3:0] obs;
    logic [3:0] want;
    half = tab[sel] / 2;
    if (half < 1) half = 1;
    len = 1 + dur * 1000 * C;
    tone_sel = 3'(sel);
    duration_ms = 12'(dur);
    start = 1'b1;
    step();
    start = 1'b0;
    tone_sel = 3'($urandom_range(0, 7));
    duration_ms = 12'($urandom_range(0, 9));
    vectors++;
    if (cur_period_us !== 13'(tab[sel])) begin
      miscompares++;
      $display("FAIL %s period: got %0d want %0d", tag, cur_period_us, tab[sel]);
    end
    for (int k = 1; k <= len + 1; k++) begin
      if (k < len)       want = {1'b1, 1'b0, 1'b0, (((k - 1) / (half * C)) % 2) == 1};
      else if (k == len) want = 4'b0100;
      else               want = 4'b0000;
      obs = {busy, done, err, speaker};
      vectors++;
      if (obs !== want) begin
        miscompares++;
        $display("FAIL %s k=%0d {busy,done,err,speaker}: got %b want %b", tag, k, obs, want);
      end
      if (k <= len) begin
        if (k == poke_at) begin
          start = 1'b1;
          tone_sel = 3'($urandom_range(0, 7));
        end
        step();
        start = 1'b0;
      end
    end
    last_period = tab[sel];
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    start = 1'b0;
    stop = 1'b0;
    tone_sel = '0;
    duration_ms = '0;
    step();
    step();
    vectors++;
    if ({speaker, busy, done, err, cur_period_us} !== 17'd0) begin
      miscompares++;
      $display("FAIL reset_init: got %h want 0", {speaker, busy, done, err, cur_period_us});
    end
    reset_n = 1'b1;
    step();
  endtask

  task automatic test_reset_mid_play();
    tone_sel = 3'd4;
    duration_ms = 12'd1;
    start = 1'b1;
    step();
    start = 1'b0;
    repeat (1700) step();
    vectors++;
    if ({busy, speaker} !== 2'b11) begin
      miscompares++;
      $display("FAIL reset_pre {busy,speaker}: got %b want 11", {busy, speaker});
    end
    #2;
    reset_n = 1'b0;
    #1;
    vectors++;
    if ({speaker, busy, done, err, cur_period_us} !== 17'd0) begin
      miscompares++;
      $display("FAIL reset_async: got %h want 0", {speaker, busy, done, err, cur_period_us});
    end
    step();
    reset_n = 1'b1;
    step();
    last_period = 0;
  endtask

  task automatic test_normal();
    run_play(4, 1, -1, "normal");
  endtask

  task automatic test_invalid_sel();
    for (int i = 5; i <= 7; i++) begin
      tone_sel = 3'(i);
      duration_ms = 12'($urandom_range(0, 4));
      start = 1'b1;
      step();
      start = 1'b0;
      vectors++;
      if ({err, busy, done} !== 3'b100 || cur_period_us !== 13'(last_period)) begin
        miscompares++;
        $display("FAIL invalid_sel%0d: got err,busy,done=%b period=%0d want 100 period=%0d",
                 i, {err, busy, done}, cur_period_us, last_period);
      end
      step();
      vectors++;
      if ({err, busy, done} !== 3'b000) begin
        miscompares++;
        $display("FAIL invalid_sel%0d_after: got %b want 000", i, {err, busy, done});
      end
    end
  endtask

  task automatic test_zero_duration();
    tone_sel = 3'($urandom_range(0, 4));
    duration_ms = 12'd0;
    start = 1'b1;
    step();
    start = 1'b0;
    vectors++;
    if ({busy, done, err, speaker} !== 4'b0100) begin
      miscompares++;
      $display("FAIL zero_dur_done: got %b want 0100", {busy, done, err, speaker});
    end
    for (int k = 2; k <= 4; k++) begin
      step();
      vectors++;
      if ({busy, done, err, speaker} !== 4'b0000) begin
        miscompares++;
        $display("FAIL zero_dur k=%0d: got %b want 0000", k, {busy, done, err, speaker});
      end
    end
  endtask

  task automatic test_abort();
    logic [3:0] want;
    tone_sel = 3'd0;
    duration_ms = 12'd5;
    start = 1'b1;
    step();
    start = 1'b0;
    for (int k = 1; k <= 6000; k++) begin
      want = {1'b1, 1'b0, 1'b0, (((k - 1) / (2500 * C)) % 2) == 1};
      if ((k % 500 == 0) || (k >= 4999 && k <= 5003)) begin
        vectors++;
        if ({busy, done, err, speaker} !== want) begin
          miscompares++;
          $display("FAIL abort_play k=%0d: got %b want %b", k, {busy, done, err, speaker}, want);
        end
      end
      if (k == 6000) stop = 1'b1;
      step();
      stop = 1'b0;
    end
    for (int k = 6001; k <= 6009; k++) begin
      vectors++;
      if ({busy, done, err, speaker} !== 4'b0000 || cur_period_us !== 13'd5000) begin
        miscompares++;
        $display("FAIL abort_idle k=%0d: got %b period=%0d want 0000 period=5000",
                 k, {busy, done, err, speaker}, cur_period_us);
      end
      step();
    end
    run_play($urandom_range(0, 4), 1, -1, "after_abort");
  endtask

  task automatic test_contention();
    for (int i = 0; i < 4; i++) begin
      tone_sel = 3'($urandom_range(0, 7));
      duration_ms = 12'($urandom_range(0, 3));
      start = 1'b1;
      stop = 1'b1;
      step();
      start = 1'b0;
      stop = 1'b0;
      vectors++;
      if ({busy, done, err, speaker} !== 4'b0000 || cur_period_us !== 13'(last_period)) begin
        miscompares++;
        $display("FAIL start_stop%0d: got %b period=%0d want 0000 period=%0d",
                 i, {busy, done, err, speaker}, cur_period_us, last_period);
      end
    end
    step();
  endtask

  task automatic test_random_plays();
    int sel;
    int dur;
    for (int i = 0; i < 3; i++) begin
      sel = $urandom_range(0, 4);
      dur = $urandom_range(1, 2);
      run_play(sel, dur, $urandom_range(1, dur * 1000 * C), "random");
    end
  endtask

  task automatic test_back_to_back();
    run_play(3, 1, 1 + 1000 * C, "b2b_done_poke");
    run_play($urandom_range(0, 4), 1, -1, "b2b_second");
  endtask

  initial begin
    test_reset();
    test_normal();
    test_invalid_sel();
    test_zero_duration();
    test_normal();
    test_contention();
    test_random_plays();
    test_abort();
    test_back_to_back();
    test_reset_mid_play();
    test_normal();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
